pic_priority_resolver: RTL and testbench
========================================

Name: pic_priority_resolver

Overview:
- Clocked interrupt arbiter for the 8259-style PIC: owns IRR/ISR, picks the winning IR line, and drives INT and the INTA sequence.
- Shares the single CPU interrupt path between eight requesters under fully-nested priority, with optional rotation.
- Sits between the IR input pins and the control unit. The control unit supplies the mask, trigger mode, AEOI and EOI/priority commands, and consumes VECTOR_NUM.

Parameters:
- SYNC_STAGES, 2, number of flops synchronizing IR[7:0] to CLK (legal range 1 to 3).
- SPURIOUS_LEVEL, 7, IR number reported when an acknowledge finds no valid request.

Ports:
- CLK input 1: single clock, all state on rising edge.
- RST input 1: asynchronous, active-high reset.
- IR input 8: raw interrupt request lines.
- LEVEL_TRIG input 1: 1 = level-triggered, 0 = rising-edge-triggered.
- IMR input 8: interrupt mask, 1 = masked.
- AEOI input 1: automatic end of interrupt at the second INTA.
- INTA1_PULSE input 1: one-cycle pulse for the first acknowledge.
- INTA2_PULSE input 1: one-cycle pulse for the second acknowledge.
- EOI_CMD input 1: one-cycle EOI strobe.
- EOI_SPECIFIC input 1: 1 = clear ISR[EOI_LEVEL], 0 = nonspecific.
- EOI_ROTATE input 1: rotate priority on this EOI.
- EOI_LEVEL input 3: level for a specific EOI.
- SET_PRIO input 1: one-cycle strobe that loads the lowest-priority level.
- PRIO_LEVEL input 3: new lowest-priority IR.
- INT output 1: interrupt request to the CPU.
- VECTOR_NUM output 3: acknowledged IR number.
- VECTOR_VALID output 1: one-cycle pulse, VECTOR_NUM valid.
- IRR output 8: interrupt request register.
- ISR output 8: in-service register.
- BUSY output 1: high while in the ACK state.

Behaviour:
- Reset (async) clears:
  - IRR, ISR, INT, VECTOR_VALID and BUSY to 0.
  - VECTOR_NUM to 0.
  - Sync flops and the edge-history register to 0.
  - Lowest-priority register LP to 7, so IR0 is highest.
  - FSM goes to IDLE. Reset mid-sequence abandons the acknowledge with no vector issued.
- Request capture: IR passes through SYNC_STAGES flops giving irs.
  - Edge mode: IRR[i] sets on the cycle after irs[i] goes 0 to 1.
  - Level mode: IRR[i] follows irs[i] one cycle later.
  - In both modes IRR[i] clears when the INTA1 pulse selects that bit.
- Priority order: levels LP+1, LP+2, ... LP+8, all mod 8 (first is highest).
- Candidate: the highest-priority set bit of IRR & ~IMR.
- Eligibility: the candidate is eligible only if strictly higher priority than the highest set ISR bit. An empty ISR always admits.
- FSM:
  - IDLE: when an eligible candidate exists, register INT=1 on the next edge and go to PEND.
  - PEND: if the candidate disappears (mask, level drop, higher ISR), INT goes to 0 and the FSM returns to IDLE.
  - PEND, on INTA1_PULSE:
    - Latch the winner W, set ISR[W], clear IRR[W], INT=0, go to ACK, BUSY=1.
    - If no candidate exists, latch W=SPURIOUS_LEVEL and leave ISR and IRR unchanged.
  - ACK, on INTA2_PULSE:
    - VECTOR_NUM=W and VECTOR_VALID=1 for one cycle; return to IDLE.
    - If AEOI=1 and the acknowledge was not spurious, clear ISR[W] in the same edge.
  - INTA2_PULSE outside ACK and INTA1_PULSE outside PEND are ignored.
- EOI_CMD, accepted in any state:
  - Nonspecific clears the highest-priority set ISR bit. If ISR is empty it is a no-op.
  - Specific clears ISR[EOI_LEVEL].
  - With EOI_ROTATE, LP is set to the cleared level. A nonspecific EOI on an empty ISR leaves LP unchanged.
- SET_PRIO: LP=PRIO_LEVEL on the next edge.
  - SET_PRIO takes precedence over EOI rotation in the same cycle.
- Simultaneous events in one cycle:
  - EOI clear and INTA1 set on the same ISR bit: the set wins.
  - An IRR set from a new edge and an INTA1 clear on the same bit: the clear wins.
- Latency: IR rising at a pin gives INT=1 after SYNC_STAGES+2 edges when idle and unmasked.

Optional Feature:
- Macro: PIC_ROTATE_EN.
- Defined: EOI_ROTATE, SET_PRIO and AEOI-rotate are all active.
  - AEOI-rotate: when AEOI=1, INTA2 also sets LP=W.
- Undefined:
  - LP is fixed at 7.
  - EOI_ROTATE, SET_PRIO and PRIO_LEVEL are ignored, and their logic is removed.
  - Priority is IR0 highest down to IR7 lowest.

Test Plan:
- Single IR: edge mode, IMR=0x00, pulse IR[3] high, SYNC_STAGES=2.
  - INT=1 four edges later.
  - INTA1 gives ISR=0x08, IRR=0x00.
  - INTA2 gives VECTOR_VALID with VECTOR_NUM=3.
  - Then nonspecific EOI gives ISR=0x00.
- Nesting: IR5 in service (ISR=0x20), assert IR2, then IR6.
  - IR2 raises INT and is acknowledged, giving ISR=0x24.
  - IR6 does not raise INT until both ISR bits are cleared by EOIs.
- Spurious: level mode, IR[4] high raises INT, drop IR[4] and pulse INTA1 in the same cycle.
  - INTA2 gives VECTOR_NUM=7.
  - ISR stays 0x00.
- AEOI: AEOI=1, IR0 acknowledged.
  - VECTOR_NUM=0.
  - ISR returns to 0x00 on the INTA2 edge; no EOI needed.
- Rotation (PIC_ROTATE_EN): IR1 and IR2 pending, acknowledge IR1, then a rotating nonspecific EOI.
  - LP=1.
  - A new request on IR1 now loses to pending IR2.
  - SET_PRIO with PRIO_LEVEL=7 restores IR0 highest.
- Reset: assert RST between INTA1 and INTA2.
  - INT=0, ISR=0, IRR=0, LP=7.
  - No VECTOR_VALID.
  - Fresh INTA2 pulses after reset are ignored.

Source files
------------

// File: rtl/pic_priority_resolver.sv
// 8259-style interrupt priority resolver: IRR/ISR ownership, rotating priority and INTA sequencing.
// Optional PIC_ROTATE_EN enables EOI rotation, SET_PRIO and AEOI rotation; otherwise IR0 is fixed highest.
module pic_priority_resolver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SPURIOUS_LEVEL = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IR,
  input  logic       LEVEL_TRIG,
  input  logic [7:0] IMR,
  input  logic       AEOI,
  input  logic       INTA1_PULSE,
  input  logic       INTA2_PULSE,
  input  logic       EOI_CMD,
  input  logic       EOI_SPECIFIC,
  input  logic       EOI_ROTATE,
  input  logic [2:0] EOI_LEVEL,
  input  logic       SET_PRIO,
  input  logic [2:0] PRIO_LEVEL,
  output logic       INT,
  output logic [2:0] VECTOR_NUM,
  output logic       VECTOR_VALID,
  output logic [7:0] IRR,
  output logic [7:0] ISR,
  output logic       BUSY
);

  typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] w_irs, r_irs_prev;
  logic [7:0] r_irr, w_irr_d;
  logic [7:0] r_isr, w_isr_d;
  logic [2:0] r_win, w_win_d;
  logic       r_spur, w_spur_d;
  logic [2:0] r_vec, w_vec_d;
  logic       r_vvalid, w_vvalid_d;
  logic [2:0] w_lp;

  logic [3:0] w_cand, w_isr_top;
  logic [2:0] w_cand_rank, w_isr_rank;
  logic       w_elig;
  logic [7:0] w_inta1_sel, w_aeoi_clr, w_eoi_clr;
  logic       w_aeoi_rot, w_eoi_hit;
  logic [2:0] w_eoi_lvl;

  // Returns {found, level} of the highest-priority set bit, scanning LP+1 .. LP+8.
  function automatic logic [3:0] f_pick(input logic [7:0] v, input logic [2:0] lp);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      lvl = lp + 3'd1 + 3'(k);
      if (v[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 8'h00;
    end else begin
      r_sync[0] <= IR;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_irs = r_sync[SYNC_STAGES-1];

  assign w_cand      = f_pick(r_irr & ~IMR, w_lp);
  assign w_isr_top   = f_pick(r_isr, w_lp);
  assign w_cand_rank = w_cand[2:0] - w_lp - 3'd1;
  assign w_isr_rank  = w_isr_top[2:0] - w_lp - 3'd1;
  assign w_elig      = w_cand[3] && (!w_isr_top[3] || (w_cand_rank < w_isr_rank));

  always_comb begin
    w_state_d   = r_state;
    w_win_d     = r_win;
    w_spur_d    = r_spur;
    w_vec_d     = r_vec;
    w_vvalid_d  = 1'b0;
    w_inta1_sel = 8'h00;
    w_aeoi_clr  = 8'h00;
    w_aeoi_rot  = 1'b0;
    unique case (r_state)
      StIdle: if (w_elig) w_state_d = StPend;
      StPend: begin
        if (INTA1_PULSE) begin
          w_state_d = StAck;
          if (w_elig) begin
            w_win_d     = w_cand[2:0];
            w_spur_d    = 1'b0;
            w_inta1_sel = 8'b1 << w_cand[2:0];
          end else begin
            w_win_d  = 3'(SPURIOUS_LEVEL);
            w_spur_d = 1'b1;
          end
        end else if (!w_elig) begin
          w_state_d = StIdle;
        end
      end
      StAck: begin
        if (INTA2_PULSE) begin
          w_state_d  = StIdle;
          w_vec_d    = r_win;
          w_vvalid_d = 1'b1;
          if (AEOI && !r_spur) begin
            w_aeoi_clr = 8'b1 << r_win;
            w_aeoi_rot = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_eoi_clr = 8'h00;
    w_eoi_hit = 1'b0;
    w_eoi_lvl = EOI_LEVEL;
    if (EOI_CMD) begin
      if (EOI_SPECIFIC) begin
        w_eoi_clr = 8'b1 << EOI_LEVEL;
        w_eoi_hit = 1'b1;
      end else if (w_isr_top[3]) begin
        w_eoi_lvl = w_isr_top[2:0];
        w_eoi_clr = 8'b1 << w_isr_top[2:0];
        w_eoi_hit = 1'b1;
      end
    end
  end

  // INTA1 clear beats a same-cycle new edge; INTA1 set beats a same-cycle EOI clear.
  always_comb begin
    if (LEVEL_TRIG) w_irr_d = w_irs & ~w_inta1_sel;
    else            w_irr_d = (r_irr | (w_irs & ~r_irs_prev)) & ~w_inta1_sel;
    w_isr_d = (r_isr & ~w_aeoi_clr & ~w_eoi_clr) | w_inta1_sel;
  end

`ifdef PIC_ROTATE_EN
  logic [2:0] r_lp, w_lp_d;

  always_comb begin
    w_lp_d = r_lp;
    if (w_aeoi_rot)                       w_lp_d = r_win;
    if (EOI_CMD && EOI_ROTATE && w_eoi_hit) w_lp_d = w_eoi_lvl;
    if (SET_PRIO)                         w_lp_d = PRIO_LEVEL;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_lp <= 3'd7;
    else     r_lp <= w_lp_d;
  end

  assign w_lp = r_lp;
`else
  logic w_unused;
  assign w_unused = ^{EOI_ROTATE, SET_PRIO, PRIO_LEVEL, w_aeoi_rot, w_eoi_lvl, w_eoi_hit};
  assign w_lp     = 3'd7;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= StIdle;
      r_irs_prev <= 8'h00;
      r_irr      <= 8'h00;
      r_isr      <= 8'h00;
      r_win      <= 3'd0;
      r_spur     <= 1'b0;
      r_vec      <= 3'd0;
      r_vvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_irs_prev <= w_irs;
      r_irr      <= w_irr_d;
      r_isr      <= w_isr_d;
      r_win      <= w_win_d;
      r_spur     <= w_spur_d;
      r_vec      <= w_vec_d;
      r_vvalid   <= w_vvalid_d;
    end
  end

  assign INT          = (r_state == StPend);
  assign BUSY         = (r_state == StAck);
  assign VECTOR_NUM   = r_vec;
  assign VECTOR_VALID = r_vvalid;
  assign IRR          = r_irr;
  assign ISR          = r_isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed self-checking bench for pic_priority_resolver (SYNC_STAGES=2, SPURIOUS_LEVEL=7).
module tb_pic_priority_resolver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IR = 8'h00;
  logic       LEVEL_TRIG = 1'b0;
  logic [7:0] IMR = 8'h00;
  logic       AEOI = 1'b0;
  logic       INTA1_PULSE = 1'b0;
  logic       INTA2_PULSE = 1'b0;
  logic       EOI_CMD = 1'b0;
  logic       EOI_SPECIFIC = 1'b0;
  logic       EOI_ROTATE = 1'b0;
  logic [2:0] EOI_LEVEL = 3'd0;
  logic       SET_PRIO = 1'b0;
  logic [2:0] PRIO_LEVEL = 3'd0;
  logic       INT;
  logic [2:0] VECTOR_NUM;
  logic       VECTOR_VALID;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic       BUSY;

  int n_total = 0;
  int n_bad   = 0;

`ifdef PIC_ROTATE_EN
  localparam logic [2:0] RotWinner = 3'd2;
`else
  localparam logic [2:0] RotWinner = 3'd1;
`endif

  pic_priority_resolver #(
    .SYNC_STAGES   (2),
    .SPURIOUS_LEVEL(7)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IR          (IR),
    .LEVEL_TRIG  (LEVEL_TRIG),
    .IMR         (IMR),
    .AEOI        (AEOI),
    .INTA1_PULSE (INTA1_PULSE),
    .INTA2_PULSE (INTA2_PULSE),
    .EOI_CMD     (EOI_CMD),
    .EOI_SPECIFIC(EOI_SPECIFIC),
    .EOI_ROTATE  (EOI_ROTATE),
    .EOI_LEVEL   (EOI_LEVEL),
    .SET_PRIO    (SET_PRIO),
    .PRIO_LEVEL  (PRIO_LEVEL),
    .INT         (INT),
    .VECTOR_NUM  (VECTOR_NUM),
    .VECTOR_VALID(VECTOR_VALID),
    .IRR         (IRR),
    .ISR         (ISR),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic inta1;
    INTA1_PULSE = 1'b1;
    tick();
    INTA1_PULSE = 1'b0;
  endtask

  task automatic inta2;
    INTA2_PULSE = 1'b1;
    tick();
    INTA2_PULSE = 1'b0;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    EOI_CMD      = 1'b1;
    EOI_SPECIFIC = spec;
    EOI_LEVEL    = lvl;
    EOI_ROTATE   = rot;
    tick();
    EOI_CMD      = 1'b0;
    EOI_SPECIFIC = 1'b0;
    EOI_ROTATE   = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int n;
    n = 0;
    while (INT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, INT, 1);
  endtask

  initial begin
    ticks(2);
    RST = 1'b0;
    check("rst int", INT, 0);
    check("rst irr", IRR, 8'h00);
    check("rst isr", ISR, 8'h00);
    check("rst busy", BUSY, 0);
    check("rst vvalid", VECTOR_VALID, 0);
    check("rst vnum", VECTOR_NUM, 0);

    // Single IR3, edge mode: INT exactly four edges after the pin rises
    IR = 8'h08;
    ticks(3);
    check("t1 irr early", IRR, 8'h08);
    check("t1 int early", INT, 0);
    tick();
    check("t1 int latency", INT, 1);
    IR = 8'h00;
    inta1();
    check("t1 isr", ISR, 8'h08);
    check("t1 irr cleared", IRR, 8'h00);
    check("t1 int low", INT, 0);
    check("t1 busy", BUSY, 1);
    inta2();
    check("t1 vvalid", VECTOR_VALID, 1);
    check("t1 vnum", VECTOR_NUM, 3);
    check("t1 busy low", BUSY, 0);
    tick();
    check("t1 vvalid pulse", VECTOR_VALID, 0);
    eoi(1'b0, 3'd0, 1'b0);
    check("t1 eoi isr", ISR, 8'h00);

    // Nesting: IR5 in service, IR2 preempts, IR6 waits for both EOIs
    IR = 8'h20;
    wait_int("t2 ir5 int");
    IR = 8'h00;
    inta1();
    inta2();
    check("t2 isr5", ISR, 8'h20);
    IR = 8'h04;
    wait_int("t2 ir2 int");
    IR = 8'h00;
    inta1();
    check("t2 isr nest", ISR, 8'h24);
    inta2();
    check("t2 vnum2", VECTOR_NUM, 2);
    IR = 8'h40;
    ticks(6);
    check("t2 ir6 blocked", INT, 0);
    check("t2 irr6", IRR, 8'h40);
    IR = 8'h00;
    eoi(1'b0, 3'd0, 1'b0);
    check("t2 eoi1 isr", ISR, 8'h20);
    ticks(2);
    check("t2 ir6 still blocked", INT, 0);
    eoi(1'b0, 3'd0, 1'b0);
    check("t2 eoi2 isr", ISR, 8'h00);
    tick();
    check("t2 ir6 int", INT, 1);
    inta1();
    inta2();
    check("t2 vnum6", VECTOR_NUM, 6);
    eoi(1'b1, 3'd6, 1'b0);
    check("t2 specific eoi", ISR, 8'h00);

    // Spurious: level mode, IR4 drop reaches IRR just as INTA1 arrives
    LEVEL_TRIG = 1'b1;
    IR = 8'h10;
    wait_int("t3 int");
    IR = 8'h00;
    ticks(3);
    check("t3 int held", INT, 1);
    check("t3 irr dropped", IRR, 8'h00);
    inta1();
    check("t3 isr untouched", ISR, 8'h00);
    check("t3 busy", BUSY, 1);
    inta2();
    check("t3 vvalid", VECTOR_VALID, 1);
    check("t3 vnum spurious", VECTOR_NUM, 7);
    check("t3 isr after", ISR, 8'h00);
    LEVEL_TRIG = 1'b0;
    ticks(2);

    // AEOI: ISR cleared on the INTA2 edge
    AEOI = 1'b1;
    IR = 8'h01;
    wait_int("t4 int");
    IR = 8'h00;
    inta1();
    check("t4 isr set", ISR, 8'h01);
    inta2();
    check("t4 vnum", VECTOR_NUM, 0);
    check("t4 isr aeoi", ISR, 8'h00);
    AEOI = 1'b0;
    ticks(2);

    // Rotation: IR1 served, rotating EOI; new IR1 then competes with pending IR2
    IR = 8'h06;
    wait_int("t5 int");
    IR = 8'h00;
    inta1();
    inta2();
    check("t5 vnum first", VECTOR_NUM, 1);
    check("t5 irr pending", IRR, 8'h04);
    ticks(3);
    IR = 8'h02;
    ticks(4);
    check("t5 irr both", IRR, 8'h06);
    IR = 8'h00;
    eoi(1'b0, 3'd0, 1'b1);
    check("t5 rot eoi isr", ISR, 8'h00);
    wait_int("t5 int2");
    inta1();
    inta2();
    check("t5 rotated winner", VECTOR_NUM, RotWinner);
    eoi(1'b0, 3'd0, 1'b0);
    SET_PRIO = 1'b1;
    PRIO_LEVEL = 3'd7;
    tick();
    SET_PRIO = 1'b0;
    wait_int("t5 int3");
    inta1();
    inta2();
    check("t5 remaining", VECTOR_NUM, (RotWinner == 3'd2) ? 3'd1 : 3'd2);
    eoi(1'b0, 3'd0, 1'b0);
    check("t5 isr clear", ISR, 8'h00);
    // IR0 highest again after SET_PRIO 7 (or fixed priority)
    IR = 8'h03;
    wait_int("t5 int4");
    IR = 8'h00;
    inta1();
    inta2();
    check("t5 ir0 highest", VECTOR_NUM, 0);
    eoi(1'b0, 3'd0, 1'b0);
    wait_int("t5 int5");
    inta1();
    inta2();
    check("t5 ir1 next", VECTOR_NUM, 1);
    eoi(1'b0, 3'd0, 1'b0);
    ticks(2);

    // Reset between INTA1 and INTA2
    IR = 8'h02;
    wait_int("t6 int");
    IR = 8'h00;
    inta1();
    check("t6 isr before rst", ISR, 8'h02);
    RST = 1'b1;
    #2;
    check("t6 rst int", INT, 0);
    check("t6 rst isr", ISR, 8'h00);
    check("t6 rst irr", IRR, 8'h00);
    check("t6 rst busy", BUSY, 0);
    tick();
    RST = 1'b0;
    inta2();
    check("t6 no vvalid", VECTOR_VALID, 0);
    check("t6 vnum zero", VECTOR_NUM, 0);
    tick();
    check("t6 no vvalid later", VECTOR_VALID, 0);
    // LP back to 7: IR0 beats IR7
    IR = 8'h81;
    wait_int("t6 int2");
    IR = 8'h00;
    inta1();
    inta2();
    check("t6 ir0 first", VECTOR_NUM, 0);
    check("t6 irr7 left", IRR, 8'h80);
    eoi(1'b0, 3'd0, 1'b0);
    wait_int("t6 int3");
    inta1();
    inta2();
    check("t6 ir7 next", VECTOR_NUM, 7);
    eoi(1'b0, 3'd0, 1'b0);
    check("t6 isr end", ISR, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
